v_conv_seq: RTL and testbench
=============================

# v_conv_seq

Sequencer that drives the vector ALU (`v_execute`) through a complete 5-row convolution for one output row. The full step list is CONV1 and accumulate per kernel row, then bias, quantize, ReLU, and write-back. It sits between the scalar issue stage and the vector datapath, and owns the ALU opcode/operand buses and one vector register-file (VRF) write port while busy. It frees software from issuing the 14 per-row vector instructions individually.

## Interface
Parameters:
- `VLEN`, 512, vector register width in bits (matches `VREG_BUS`).
- `VRA_W`, 5, VRF address width.
- `KROWS`, 5, kernel rows accumulated per output row.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  start request; sampled only in IDLE.
- `in_base_i`  in  VRA_W  VRF index of input row 0; rows are at consecutive indices.
- `w_base_i`  in  VRA_W  VRF index of kernel row 0; rows are at consecutive indices.
- `bias_reg_i`  in  VRA_W  VRF index holding 16-bit biases.
- `shift_i`  in  8  quantization right-shift amount.
- `dst_reg_i`  in  VRA_W  VRF write-back index.
- `stall_i`  in  1  freezes the sequencer for that cycle.
- `busy_o`  out  1  high from the cycle after start is accepted through the DONE state.
- `done_o`  out  1  one-cycle pulse when the result is written.
- `vrf_raddr1_o`, `vrf_raddr2_o`  out  VRA_W  VRF read addresses; reads are combinational.
- `vrf_rdata1_i`, `vrf_rdata2_i`  in  VLEN  VRF read data.
- `valu_opcode_o`  out  `ALU_OP_BUS`  ALU opcode.
- `operand_v1_o`, `operand_v2_o`  out  VLEN  ALU operands.
- `valu_result_i`  in  VLEN  ALU result; combinational, same cycle as the operands.
- `vrf_we_o`  out  1  VRF write enable.
- `vrf_waddr_o`  out  VRA_W  VRF write address.
- `vrf_wdata_o`  out  VLEN  VRF write data.

## Operation
Each state is one ALU cycle. The ALU result is captured at the end of that cycle into `acc` or `tmp` (both VLEN registers). Registered parameters are latched from the inputs when start is accepted.

States and transitions:
- IDLE
  - Opcode is `VALU_OP_NOP`.
  - `start_i` causes: latch all inputs, `acc<=0`, `row<=0`, go to CONV.
- CONV
  - `raddr1=in_base+row`, `raddr2=w_base+row`, opcode `VALU_OP_CONV1`.
  - `v1=rdata1`, `v2=rdata2`; `tmp<=result`.
  - Go to ACC.
- ACC
  - Opcode `VALU_OP_ADD`, `v1=acc`, `v2=tmp`; `acc<=result`.
  - If `row==KROWS-1`, go to BIAS; otherwise `row<=row+1` and go to CONV.
- BIAS
  - `raddr1=bias_reg`, opcode `VALU_OP_BIAS16`, `v1=acc`, `v2=rdata1`; `acc<=result`.
  - Only lanes 0..9 receive a bias.
- QUAN
  - Opcode `VALU_OP_QUAN32`, `v1={0, shift}`, `v2=acc`; `tmp<=result`.
- RELU
  - Opcode `VALU_OP_RELU`, `v2=tmp`; `tmp<=result`.
- WB
  - `vrf_we=1`, `waddr=dst`, `wdata=tmp`; opcode NOP.
- DONE
  - `done_o=1`, go to IDLE.

Rules:
- VRF addresses add modulo 2^VRA_W, so they wrap.
- Operand and address outputs are 0 in any state that does not use them.
- When `stall_i` is high in any non-IDLE state:
  - state, `row`, `acc` and `tmp` hold;
  - opcode and operands continue to reflect the held state;
  - `vrf_we_o` and `done_o` are forced to 0 for that cycle.
- In IDLE, `stall_i` has no effect and start is still accepted.
- `start_i` while busy is ignored and not queued.
- `start_i` high in DONE is ignored. Start can next be accepted in the IDLE cycle that follows.

## Timing
- Reset values: all outputs 0, opcode NOP, state IDLE, `acc`/`tmp`/`row` 0.
- Reset asserted mid-sequence aborts immediately. No write occurs and no done pulse is produced.
- Unstalled latency, with start sampled at edge 0:
  - CONV row 0 occupies cycle 1.
  - WB occupies cycle 14.
  - `done_o` is high in cycle 15.
  - IDLE resumes in cycle 16.
- Each stall cycle adds exactly one cycle of latency.
- `busy_o` is high in cycles 1..15.
- `vrf_we_o` is high in exactly one cycle per job.

## Structure
- State encoding belongs in `v_defines.v` as `VSEQ_*` constants next to the `VALU_OP_*` codes.
- The block reuses the existing `VALU_OP_*` codes.
- `v_execute` is instantiated externally, not inside this block.
- A flat FSM is sufficient; no sub-module is natural. The row counter is 3 bits, inline.

## Test plan
- Basic job:
  - Stimulus: input bytes 1, kernel bytes 1, bias halfwords 3, shift 2.
  - Required: written lanes 0..9 = 0x07, lanes 10..13 = 0x06, lanes 14..31 = 0x00.
  - Required: `done_o` pulses in cycle 15.
- Negative kernel:
  - Stimulus: kernel bytes 0xFF, otherwise as the basic job.
  - Required: all written bytes 0x00 (ReLU clamps).
- Stall:
  - Stimulus: `stall_i` high for 3 cycles during ACC of row 2.
  - Required: identical result; `done_o` in cycle 18.
  - Required: ACC opcode held for the 3 stall cycles.
- Stall in WB:
  - Stimulus: `stall_i` high in WB for 2 cycles.
  - Required: `vrf_we_o` is 0 during the stall and asserts once afterward.
- Base wrap and ignored start:
  - Stimulus: `in_base=30`.
  - Required: reads hit indices 30, 31, 0, 1, 2.
  - Stimulus: `start_i` pulsed while busy.
  - Required: exactly one write.
- Async reset:
  - Stimulus: `rst` at cycle 7.
  - Required: outputs go 0 asynchronously; no write or done occurs.
  - Stimulus: a new start after reset.
  - Required: the job completes normally.

Source files
------------

// File: rtl/v_conv_seq_pkg.sv
// v_conv_seq_pkg: vector ALU opcodes and convolution sequencer state encoding
package v_conv_seq_pkg;
    localparam int ALU_OP_BUS = 5;
    typedef logic [ALU_OP_BUS-1:0] valu_op_t;
    localparam valu_op_t VALU_OP_NOP    = 5'd0;
    localparam valu_op_t VALU_OP_ADD    = 5'd1;
    localparam valu_op_t VALU_OP_CONV1  = 5'd2;
    localparam valu_op_t VALU_OP_BIAS16 = 5'd3;
    localparam valu_op_t VALU_OP_QUAN32 = 5'd4;
    localparam valu_op_t VALU_OP_RELU   = 5'd5;
    typedef enum logic [2:0] {
        VSEQ_IDLE, VSEQ_CONV, VSEQ_ACC, VSEQ_BIAS, VSEQ_QUAN, VSEQ_RELU, VSEQ_WB, VSEQ_DONE
    } vseq_state_t;
endpackage

// File: rtl/v_conv_seq.sv
// v_conv_seq: drives the vector ALU through a 5-row convolution, bias, quantize, ReLU and write-back
module v_conv_seq
    import v_conv_seq_pkg::*;
#(
    parameter int VLEN  = 512,
    parameter int VRA_W = 5,
    parameter int KROWS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [VRA_W-1:0]      in_base_i,
    input  logic [VRA_W-1:0]      w_base_i,
    input  logic [VRA_W-1:0]      bias_reg_i,
    input  logic [7:0]            shift_i,
    input  logic [VRA_W-1:0]      dst_reg_i,
    input  logic                  stall_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [VRA_W-1:0]      vrf_raddr1_o,
    output logic [VRA_W-1:0]      vrf_raddr2_o,
    input  logic [VLEN-1:0]       vrf_rdata1_i,
    input  logic [VLEN-1:0]       vrf_rdata2_i,
    output logic [ALU_OP_BUS-1:0] valu_opcode_o,
    output logic [VLEN-1:0]       operand_v1_o,
    output logic [VLEN-1:0]       operand_v2_o,
    input  logic [VLEN-1:0]       valu_result_i,
    output logic                  vrf_we_o,
    output logic [VRA_W-1:0]      vrf_waddr_o,
    output logic [VLEN-1:0]       vrf_wdata_o
);
    vseq_state_t      state;
    logic [2:0]       row;
    logic [VLEN-1:0]  acc, tmp;
    logic [VRA_W-1:0] in_base, w_base, bias_reg, dst;
    logic [7:0]       shift;
    logic             is_conv, is_acc, is_bias, is_quan, is_relu, is_wb, is_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= VSEQ_IDLE;
            row      <= '0;
            acc      <= '0;
            tmp      <= '0;
            in_base  <= '0;
            w_base   <= '0;
            bias_reg <= '0;
            shift    <= '0;
            dst      <= '0;
        end else if (state == VSEQ_IDLE) begin
            if (start_i) begin
                in_base  <= in_base_i;
                w_base   <= w_base_i;
                bias_reg <= bias_reg_i;
                shift    <= shift_i;
                dst      <= dst_reg_i;
                acc      <= '0;
                row      <= '0;
                state    <= VSEQ_CONV;
            end
        end else if (!stall_i) begin
            case (state)
                VSEQ_CONV: begin
                    tmp   <= valu_result_i;
                    state <= VSEQ_ACC;
                end
                VSEQ_ACC: begin
                    acc <= valu_result_i;
                    if (row == 3'(KROWS - 1)) begin
                        state <= VSEQ_BIAS;
                    end else begin
                        row   <= row + 3'd1;
                        state <= VSEQ_CONV;
                    end
                end
                VSEQ_BIAS: begin
                    acc   <= valu_result_i;
                    state <= VSEQ_QUAN;
                end
                VSEQ_QUAN: begin
                    tmp   <= valu_result_i;
                    state <= VSEQ_RELU;
                end
                VSEQ_RELU: begin
                    tmp   <= valu_result_i;
                    state <= VSEQ_WB;
                end
                VSEQ_WB:   state <= VSEQ_DONE;
                default:   state <= VSEQ_IDLE;
            endcase
        end
    end

    assign is_conv = state == VSEQ_CONV;
    assign is_acc  = state == VSEQ_ACC;
    assign is_bias = state == VSEQ_BIAS;
    assign is_quan = state == VSEQ_QUAN;
    assign is_relu = state == VSEQ_RELU;
    assign is_wb   = state == VSEQ_WB;
    assign is_done = state == VSEQ_DONE;

    // Outputs decode the current state; a stall only suppresses the side-effecting strobes.
    assign busy_o        = state != VSEQ_IDLE;
    assign done_o        = is_done && !stall_i;
    assign vrf_we_o      = is_wb && !stall_i;
    assign vrf_waddr_o   = is_wb ? dst : '0;
    assign vrf_wdata_o   = is_wb ? tmp : '0;
    assign vrf_raddr1_o  = is_conv ? in_base + VRA_W'(row) : is_bias ? bias_reg : '0;
    assign vrf_raddr2_o  = is_conv ? w_base + VRA_W'(row) : '0;
    assign valu_opcode_o = is_conv ? VALU_OP_CONV1 : is_acc ? VALU_OP_ADD : is_bias ? VALU_OP_BIAS16 :
                           is_quan ? VALU_OP_QUAN32 : is_relu ? VALU_OP_RELU : VALU_OP_NOP;
    assign operand_v1_o  = is_conv ? vrf_rdata1_i : (is_acc || is_bias) ? acc : is_quan ? VLEN'(shift) : '0;
    assign operand_v2_o  = is_conv ? vrf_rdata2_i : is_acc ? tmp : is_bias ? vrf_rdata1_i :
                           is_quan ? acc : is_relu ? tmp : '0;
endmodule

// File: tb/tb_v_conv_seq.sv
// tb_v_conv_seq: table-driven bench with a behavioural VRF and vector ALU around v_conv_seq
module tb_v_conv_seq;
    import v_conv_seq_pkg::*;

    logic         clk, rst, start_i, stall_i;
    logic [4:0]   in_base_i, w_base_i, bias_reg_i, dst_reg_i;
    logic [7:0]   shift_i;
    logic         busy_o, done_o, vrf_we_o;
    logic [4:0]   vrf_raddr1_o, vrf_raddr2_o, vrf_waddr_o;
    logic [511:0] vrf_rdata1_i, vrf_rdata2_i, operand_v1_o, operand_v2_o, valu_result_i, vrf_wdata_o;
    logic [4:0]   valu_opcode_o;
    logic [511:0] mem [32];
    int           checks = 0;
    int           errors = 0;

    typedef struct {
        logic [7:0]  in_b;
        logic [7:0]  w_b;
        logic [15:0] bias;
        logic [7:0]  shift;
        logic [4:0]  in_base;
        logic [31:0] stall;
        logic [31:0] starts;
        logic [7:0]  lo;
        logic [7:0]  mid;
        int          done_cyc;
    } vec_t;
    vec_t vecs [6];

    v_conv_seq dut (
        .clk(clk), .rst(rst), .start_i(start_i), .in_base_i(in_base_i), .w_base_i(w_base_i),
        .bias_reg_i(bias_reg_i), .shift_i(shift_i), .dst_reg_i(dst_reg_i), .stall_i(stall_i),
        .busy_o(busy_o), .done_o(done_o), .vrf_raddr1_o(vrf_raddr1_o), .vrf_raddr2_o(vrf_raddr2_o),
        .vrf_rdata1_i(vrf_rdata1_i), .vrf_rdata2_i(vrf_rdata2_i), .valu_opcode_o(valu_opcode_o),
        .operand_v1_o(operand_v1_o), .operand_v2_o(operand_v2_o), .valu_result_i(valu_result_i),
        .vrf_we_o(vrf_we_o), .vrf_waddr_o(vrf_waddr_o), .vrf_wdata_o(vrf_wdata_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Behavioural ALU: 16 x 32-bit lanes for conv/add/bias, byte lanes after quantization.
    function automatic logic [511:0] alu(input logic [4:0] op, input logic [511:0] a, input logic [511:0] b);
        logic [511:0]       r;
        logic signed [31:0] s, x, y;
        r = '0;
        if (op == VALU_OP_CONV1) begin
            for (int j = 0; j < 14; j++) begin
                s = 0;
                for (int k = 0; k < 5; k++) begin
                    x = 32'($signed(a[8*(j+k) +: 8]));
                    y = 32'($signed(b[8*k +: 8]));
                    s = s + x * y;
                end
                r[32*j +: 32] = s;
            end
        end else if (op == VALU_OP_ADD) begin
            for (int j = 0; j < 16; j++) r[32*j +: 32] = a[32*j +: 32] + b[32*j +: 32];
        end else if (op == VALU_OP_BIAS16) begin
            r = a;
            for (int j = 0; j < 10; j++) begin
                x = 32'($signed(b[16*j +: 16]));
                r[32*j +: 32] = a[32*j +: 32] + x;
            end
        end else if (op == VALU_OP_QUAN32) begin
            for (int j = 0; j < 16; j++) begin
                x = $signed(b[32*j +: 32]) >>> a[7:0];
                r[8*j +: 8] = (x > 127) ? 8'h7f : (x < -128) ? 8'h80 : x[7:0];
            end
        end else if (op == VALU_OP_RELU) begin
            for (int j = 0; j < 64; j++) r[8*j +: 8] = b[8*j+7] ? 8'h00 : b[8*j +: 8];
        end
        return r;
    endfunction

    always_comb begin
        vrf_rdata1_i  = mem[vrf_raddr1_o];
        vrf_rdata2_i  = mem[vrf_raddr2_o];
        valu_result_i = alu(valu_opcode_o, operand_v1_o, operand_v2_o);
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_vrf(input vec_t v);
        logic [4:0] ia;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        for (int k = 0; k < 5; k++) begin
            ia = v.in_base + 5'(k);
            mem[ia]     = {64{v.in_b}};
            mem[10 + k] = {64{v.w_b}};
        end
        mem[20] = {32{v.bias}};
        in_base_i  = v.in_base;
        w_base_i   = 5'd10;
        bias_reg_i = 5'd20;
        shift_i    = v.shift;
        dst_reg_i  = 5'd25;
    endtask

    // Reference step s: 0..9 CONV/ACC pairs, 10 BIAS, 11 QUAN, 12 RELU, 13 WB, 14 DONE, 15 idle.
    task automatic run_vec(input vec_t v, input int id);
        logic [511:0] exp_wd;
        logic [4:0]   exp_op, ea1, ea2;
        int           s, writes, dones, done_at;
        exp_wd = '0;
        for (int j = 0; j < 10; j++) exp_wd[8*j +: 8] = v.lo;
        for (int j = 10; j < 14; j++) exp_wd[8*j +: 8] = v.mid;
        load_vrf(v);
        start_i = 1;
        stall_i = 0;
        @(posedge clk);
        #1 start_i = 0;
        s = 0; writes = 0; dones = 0; done_at = -1;
        for (int n = 1; n < 32; n++) begin
            start_i = v.starts[n];
            stall_i = v.stall[n];
            @(negedge clk);
            exp_op = (s < 10) ? ((s % 2 == 0) ? VALU_OP_CONV1 : VALU_OP_ADD) : (s == 10) ? VALU_OP_BIAS16 :
                     (s == 11) ? VALU_OP_QUAN32 : (s == 12) ? VALU_OP_RELU : VALU_OP_NOP;
            ea1 = (s < 10 && s % 2 == 0) ? v.in_base + 5'(s / 2) : (s == 10) ? 5'd20 : 5'd0;
            ea2 = (s < 10 && s % 2 == 0) ? 5'd10 + 5'(s / 2) : 5'd0;
            chk($sformatf("v%0d c%0d opcode", id, n), 512'(valu_opcode_o), 512'(exp_op));
            chk($sformatf("v%0d c%0d raddr1", id, n), 512'(vrf_raddr1_o), 512'(ea1));
            chk($sformatf("v%0d c%0d raddr2", id, n), 512'(vrf_raddr2_o), 512'(ea2));
            chk($sformatf("v%0d c%0d busy", id, n), 512'(busy_o), 512'(s <= 14));
            chk($sformatf("v%0d c%0d we", id, n), 512'(vrf_we_o), 512'(s == 13 && !v.stall[n]));
            chk($sformatf("v%0d c%0d done", id, n), 512'(done_o), 512'(s == 14 && !v.stall[n]));
            chk($sformatf("v%0d c%0d waddr", id, n), 512'(vrf_waddr_o), 512'((s == 13) ? 5'd25 : 5'd0));
            chk($sformatf("v%0d c%0d wdata", id, n), vrf_wdata_o, (s == 13) ? exp_wd : 512'(0));
            if (vrf_we_o) writes++;
            if (done_o) begin
                dones++;
                done_at = n;
            end
            if (!v.stall[n] && s < 15) s++;
            @(posedge clk);
            #1;
        end
        start_i = 0;
        stall_i = 0;
        chk($sformatf("v%0d done cycle", id), 512'(done_at), 512'(v.done_cyc));
        chk($sformatf("v%0d write count", id), 512'(writes), 512'(1));
        chk($sformatf("v%0d done count", id), 512'(dones), 512'(1));
    endtask

    initial begin
        int seen;
        vecs[0] = '{8'h01, 8'h01, 16'd3, 8'd2, 5'd0,  32'h0,      32'h0,    8'h07, 8'h06, 15};
        vecs[1] = '{8'h01, 8'hff, 16'd3, 8'd2, 5'd0,  32'h0,      32'h0,    8'h00, 8'h00, 15};
        vecs[2] = '{8'h01, 8'h01, 16'd3, 8'd2, 5'd0,  32'h1c0,    32'h0,    8'h07, 8'h06, 18};
        vecs[3] = '{8'h01, 8'h01, 16'd3, 8'd2, 5'd0,  32'hc000,   32'h0,    8'h07, 8'h06, 17};
        vecs[4] = '{8'h01, 8'h01, 16'd3, 8'd2, 5'd30, 32'h0,      32'h8020, 8'h07, 8'h06, 15};
        vecs[5] = '{8'h02, 8'h01, 16'd3, 8'd1, 5'd3,  32'h100000, 32'h0,    8'h1a, 8'h19, 15};
        rst = 1; start_i = 0; stall_i = 0;
        load_vrf(vecs[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 512'(busy_o), 512'(0));
        chk("reset done", 512'(done_o), 512'(0));
        chk("reset we", 512'(vrf_we_o), 512'(0));
        chk("reset opcode", 512'(valu_opcode_o), 512'(VALU_OP_NOP));
        chk("reset v1", operand_v1_o, 512'(0));
        chk("reset v2", operand_v2_o, 512'(0));
        chk("reset wdata", vrf_wdata_o, 512'(0));
        @(posedge clk);
        #1 rst = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
        // Abort mid-job with an asynchronous reset in cycle 7.
        load_vrf(vecs[0]);
        start_i = 1;
        @(posedge clk);
        #1 start_i = 0;
        repeat (6) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("async busy", 512'(busy_o), 512'(0));
        chk("async opcode", 512'(valu_opcode_o), 512'(VALU_OP_NOP));
        chk("async raddr1", 512'(vrf_raddr1_o), 512'(0));
        chk("async raddr2", 512'(vrf_raddr2_o), 512'(0));
        chk("async v1", operand_v1_o, 512'(0));
        chk("async v2", operand_v2_o, 512'(0));
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (vrf_we_o || done_o) seen++;
        end
        @(posedge clk);
        #1 rst = 0;
        repeat (12) begin
            @(negedge clk);
            if (vrf_we_o || done_o || busy_o) seen++;
        end
        chk("no activity after abort", 512'(seen), 512'(0));
        @(posedge clk);
        #1;
        run_vec(vecs[0], 6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
